// File: rtl/gray_pkg.sv
// Gray-code helpers shared by the up/down Gray counter.
// Functions are fixed at 16 bits; callers zero-extend and truncate.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 16;

  function automatic logic [15:0] bin2gray(
    input logic [15:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [15:0] gray2bin(
    input logic [15:0] g
  );
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary to Gray encoder.
// Feeds the Gray output register from the next binary count.
module gray_enc #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g
);

  assign g = b ^ (b >> 1);

endmodule

// File: rtl/gray_updown_cnt.sv
// Up/down counter with registered Gray and binary outputs.
// Define GRAY_UPDOWN_CNT_SAT_EN to saturate instead of wrap.
import gray_pkg::*;

module gray_updown_cnt #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] bin,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  generate
    if (WIDTH < 2 || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
      $error("gray_updown_cnt: WIDTH out of range");
    end
  endgenerate

  logic [WIDTH-1:0] bin_n;
  logic [WIDTH-1:0] y_n;
  logic             tc_n;
  logic             at_end;

  always_comb begin
    bin_n  = bin;
    tc_n   = 1'b0;
    at_end = down ? (bin == '0) : (bin == MAX);
    if (load) begin
      bin_n = load_val;
    end else if (en) begin
      tc_n = at_end;
`ifdef GRAY_UPDOWN_CNT_SAT_EN
      if (!at_end) begin
        bin_n = down ? bin - ONE : bin + ONE;
      end
`else
      bin_n = down ? bin - ONE : bin + ONE;
`endif
    end
  end

  gray_enc #(
    .WIDTH(WIDTH)
  ) u_enc (
    .b(bin_n),
    .g(y_n)
  );

  // Y is encoded from bin_n so both outputs move on the same edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bin <= '0;
      Y   <= '0;
      tc  <= 1'b0;
    end else begin
      bin <= bin_n;
      Y   <= y_n;
      tc  <= tc_n;
    end
  end

endmodule

// File: doc/gray_updown_cnt.md
GRAY_UPDOWN_CNT -- requirements
Module: gray_updown_cnt

Interface
REQ-001 SHALL have parameter WIDTH, default 3: counter width in bits; legal range 2..16.
REQ-002 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  count enable; one step per CLK edge while high.
REQ-005 SHALL have port down  input  1  direction: 0 = up, 1 = down.
REQ-006 SHALL have port load  input  1  synchronous load strobe.
REQ-007 SHALL have port load_val  input  WIDTH  binary value loaded on load.
REQ-008 SHALL have port Y  output  WIDTH  registered Gray-coded count.
REQ-009 SHALL have port bin  output  WIDTH  registered binary count, equal to gray2bin(Y) at all times.
REQ-010 SHALL have port tc  output  1  registered terminal-count event flag.

Function
REQ-011 SHALL hold an internal binary count register; Y and bin SHALL both be registered and update on the same CLK edge; no negedge logic.
REQ-012 SHALL, per edge, apply priority load > en > hold.
REQ-013 SHALL, on load, set bin = load_val and Y = bin2gray(load_val) at the next edge, regardless of en and down; tc SHALL be 0 that cycle.
REQ-014 SHALL, on en & !down, step bin to bin+1 modulo 2^WIDTH.
REQ-015 SHALL, on en & down, step bin to bin-1 modulo 2^WIDTH.
REQ-016 SHALL hold bin, Y when load=0 and en=0; tc SHALL be 0.
REQ-017 SHALL change exactly one bit of Y per count step, including wrap steps.
REQ-018 SHALL set tc=1 for exactly the cycle following a wrap step (up: 2^WIDTH-1 -> 0; down: 0 -> 2^WIDTH-1), else tc=0.
REQ-019 SHALL take a direction change effect on the very next enabled edge, without a dead cycle.
REQ-020 SHALL treat bin2gray(b) = b ^ (b >> 1) and gray2bin as prefix XOR from MSB.

Reset
REQ-021 SHALL, while RST_N=0, force bin=0, Y=0, tc=0 asynchronously, overriding load and en.
REQ-022 SHALL, after RST_N rises, resume counting at the first CLK edge where en or load is high; reset asserted mid-count SHALL discard the count.

Configuration
REQ-023 SHALL support macro GRAY_UPDOWN_CNT_SAT_EN.
REQ-024 SHALL, when GRAY_UPDOWN_CNT_SAT_EN is defined, saturate instead of wrapping: up at 2^WIDTH-1 holds, down at 0 holds; tc SHALL be 1 the cycle following a blocked step.
REQ-025 SHALL, when GRAY_UPDOWN_CNT_SAT_EN is undefined, wrap per REQ-014/015/018; load behaviour is identical in both builds.

Structure
REQ-026 SHALL place in package gray_pkg: parameter-free functions bin2gray and gray2bin (width-generic via parameterised class or fixed 16-bit with truncation), and a constant GRAY_MAX_WIDTH = 16.
REQ-027 SHALL instantiate one sub-module gray_enc (WIDTH-parameterised, combinational bin -> Gray) to produce the next Y value from the next binary value.
REQ-028 SHALL check WIDTH range at elaboration and fail on illegal values.

Verification (WIDTH=3 unless stated)
REQ-029 SHALL cover up count: reset, en=1 down=0 for 9 edges -> Y = 001,011,010,110,111,101,100,000,001; tc=1 only after the 111->000 binary wrap (Y 100->000).
REQ-030 SHALL cover down count: reset, en=1 down=1 -> Y = 100,101,111,110,010,011,001,000; tc=1 the cycle after the first step (0->7).
REQ-031 SHALL cover load priority: load=1 load_val=5 en=1 down=0 -> bin=5, Y=111, tc=0; next edge load=0 -> bin=6, Y=101.
REQ-032 SHALL cover async reset mid-count: RST_N pulled low between edges at bin=4 -> bin=0, Y=000, tc=0 immediately, without a CLK edge.
REQ-033 SHALL cover saturation build (GRAY_UPDOWN_CNT_SAT_EN): load 7, en=1 up for 3 edges -> Y stays 100, tc=1 each following cycle; then down=1 -> bin=6, tc=0.
REQ-034 SHALL cover WIDTH=8 random en/down/load for 10k cycles -> every step changes exactly one Y bit and bin == gray2bin(Y) each cycle.
